// File: rtl/bomb_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bomb_pkg
//  Description : Shared types and constants for the bomb timer block
//                (slot state encoding, slot record, grid constants, helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package bomb_pkg;

    localparam int GRID_CELLS = 256;
    localparam int COORD_W    = 8;
    localparam int FUSE_W     = 8;

    localparam logic PLAYER_1 = 1'b0;
    localparam logic PLAYER_2 = 1'b1;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        ARMED   = 2'd1,
        PENDING = 2'd2
    } slot_state_t;

    typedef struct packed {
        slot_state_t          state;
        logic [COORD_W-1:0]   coord;
        logic [FUSE_W-1:0]    fuse;
    } slot_t;

    // One-hot decode of a cell index onto the board map.
    function automatic logic [GRID_CELLS-1:0] cell_onehot(input logic [COORD_W-1:0] coord);
        logic [GRID_CELLS-1:0] v;
        v        = '0;
        v[coord] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bomb_timer_slot.sv
`default_nettype none
// ============================================================================
//  Module      : bomb_slot
//  Description : One bomb slot: FREE -> ARMED (fuse loaded) -> PENDING
//                (fuse expired or hit by flame) -> FREE (explosion accepted).
//  Revision    : 1.0 - initial release
// ============================================================================
module bomb_slot
    import bomb_pkg::*;
#(
    parameter int FUSE_TICKS = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alloc_i,
    input  logic [COORD_W-1:0] coord_i,
    input  logic               tick_i,
    input  logic               flame_hit_i,
    input  logic               clear_i,
    output slot_state_t        state_o,
    output logic [COORD_W-1:0] coord_o
);

    slot_t slot_q;

    // Slot lifecycle; a flame hit forces the fuse to zero and goes pending at once,
    // a naturally expired fuse goes pending one cycle after reaching zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q.state <= FREE;
            slot_q.coord <= '0;
            slot_q.fuse  <= '0;
        end else begin
            case (slot_q.state)
                FREE: begin
                    if (alloc_i) begin
                        slot_q.state <= ARMED;
                        slot_q.coord <= coord_i;
                        slot_q.fuse  <= FUSE_W'(FUSE_TICKS);
                    end
                end
                ARMED: begin
                    if (flame_hit_i) begin
                        slot_q.state <= PENDING;
                        slot_q.fuse  <= '0;
                    end else if (slot_q.fuse == '0) begin
                        slot_q.state <= PENDING;
                    end else if (tick_i) begin
                        slot_q.fuse <= slot_q.fuse - FUSE_W'(1);
                    end
                end
                PENDING: begin
                    if (clear_i) begin
                        slot_q.state <= FREE;
                    end
                end
                default: slot_q.state <= FREE;
            endcase
        end
    end

    assign state_o = slot_q.state;
    assign coord_o = slot_q.coord;

endmodule
`default_nettype wire

// File: rtl/bomb_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bomb_timer
//  Description : Two banks of bomb slots with fuse countdown, placement
//                arbitration, occupancy map, live counts and a valid/ready
//                explosion event stream (lowest pending slot first).
//  Revision    : 1.0 - initial release
// ============================================================================
module bomb_timer
    import bomb_pkg::*;
#(
    parameter int SLOTS_PER_PLAYER = 5,
    parameter int FUSE_TICKS       = 12,
    parameter int TICK_DIV         = 25_000_000,
    parameter int TICK_W           = 25
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p1_set_bomb,
    input  logic [COORD_W-1:0]    p1_coordinate,
    input  logic                  p2_set_bomb,
    input  logic [COORD_W-1:0]    p2_coordinate,
    input  logic [GRID_CELLS-1:0] flame_map,
    input  logic                  explode_ready,
    output logic                  explode_valid,
    output logic [COORD_W-1:0]    explode_coord,
    output logic                  explode_owner,
    output logic [2:0]            bomb_num_1,
    output logic [2:0]            bomb_num_2,
    output logic [GRID_CELLS-1:0] bomb_wall_o
);

    localparam int NSLOTS = 2 * SLOTS_PER_PLAYER;
    localparam int IDX_W  = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

    logic [TICK_W-1:0]     presc_q;
    logic                  tick;

    slot_state_t           slot_state [NSLOTS];
    logic [COORD_W-1:0]    slot_coord [NSLOTS];
    logic [NSLOTS-1:0]     alloc;
    logic [NSLOTS-1:0]     clear;

    logic                  p1_has_free, p2_has_free;
    logic [IDX_W-1:0]      p1_free_idx, p2_free_idx;
    logic                  p1_accept, p2_accept;

    logic [GRID_CELLS-1:0] wall;
    logic [2:0]            cnt1, cnt2;

    logic                  pend_any;
    logic [IDX_W-1:0]      pend_idx;
    logic                  lock_q;
    logic [IDX_W-1:0]      lock_idx_q;
    logic [IDX_W-1:0]      sel_idx;
    logic                  fire;

    // Fuse prescaler: wraps every TICK_DIV cycles, tick is high on the wrap cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + TICK_W'(1);
        end
    end

    assign tick = (presc_q == TICK_W'(TICK_DIV - 1));

    generate
        for (genvar g = 0; g < NSLOTS; g++) begin : g_slot
            localparam bit IS_P2 = (g >= SLOTS_PER_PLAYER);
            bomb_slot #(
                .FUSE_TICKS (FUSE_TICKS)
            ) u_slot (
                .clk         (clk),
                .rst_n       (rst_n),
                .alloc_i     (alloc[g]),
                .coord_i     (IS_P2 ? p2_coordinate : p1_coordinate),
                .tick_i      (tick),
                .flame_hit_i (flame_map[slot_coord[g]]),
                .clear_i     (clear[g]),
                .state_o     (slot_state[g]),
                .coord_o     (slot_coord[g])
            );
        end
    endgenerate

    // Lowest-index FREE slot in each bank (descending scan so the lowest wins).
    always_comb begin
        p1_has_free = 1'b0;
        p1_free_idx = '0;
        p2_has_free = 1'b0;
        p2_free_idx = '0;
        for (int i = SLOTS_PER_PLAYER - 1; i >= 0; i--) begin
            if (slot_state[i] == FREE) begin
                p1_has_free = 1'b1;
                p1_free_idx = IDX_W'(i);
            end
            if (slot_state[i + SLOTS_PER_PLAYER] == FREE) begin
                p2_has_free = 1'b1;
                p2_free_idx = IDX_W'(i + SLOTS_PER_PLAYER);
            end
        end
    end

    // Player 1 takes priority when both players claim the same empty cell.
    assign p1_accept = p1_set_bomb && p1_has_free && !wall[p1_coordinate];
    assign p2_accept = p2_set_bomb && p2_has_free && !wall[p2_coordinate]
                       && !(p1_accept && (p1_coordinate == p2_coordinate));

    // Per-slot allocate and clear strobes.
    always_comb begin
        alloc = '0;
        clear = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            alloc[i] = (p1_accept && (p1_free_idx == IDX_W'(i)))
                    || (p2_accept && (p2_free_idx == IDX_W'(i)));
            clear[i] = fire && (sel_idx == IDX_W'(i));
        end
    end

    // Occupancy map and live counts, derived from registered slot state.
    always_comb begin
        wall = '0;
        cnt1 = '0;
        cnt2 = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (slot_state[i] != FREE) begin
                wall = wall | cell_onehot(slot_coord[i]);
                if (i < SLOTS_PER_PLAYER) begin
                    cnt1 = cnt1 + 3'd1;
                end else begin
                    cnt2 = cnt2 + 3'd1;
                end
            end
        end
    end

    // Lowest-index PENDING slot.
    always_comb begin
        pend_any = 1'b0;
        pend_idx = '0;
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (slot_state[i] == PENDING) begin
                pend_any = 1'b1;
                pend_idx = IDX_W'(i);
            end
        end
    end

    // Once an event is shown and stalled, pin it so a lower slot turning pending
    // cannot change the presented event before it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (explode_valid && !explode_ready) begin
            lock_q     <= 1'b1;
            lock_idx_q <= sel_idx;
        end else begin
            lock_q     <= 1'b0;
        end
    end

    assign sel_idx       = lock_q ? lock_idx_q : pend_idx;
    assign explode_valid = lock_q || pend_any;
    assign fire          = explode_valid && explode_ready;
    assign explode_owner = (explode_valid && (sel_idx >= IDX_W'(SLOTS_PER_PLAYER)))
                           ? PLAYER_2 : PLAYER_1;

    // Coordinate of the presented slot, zero when nothing is presented.
    always_comb begin
        explode_coord = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (explode_valid && (sel_idx == IDX_W'(i))) begin
                explode_coord = slot_coord[i];
            end
        end
    end

    assign bomb_wall_o = wall;
    assign bomb_num_1  = cnt1;
    assign bomb_num_2  = cnt2;

endmodule
`default_nettype wire

// File: tb/tb_bomb_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bomb_timer
//  Description : Directed self-checking bench for bomb_timer (short tick and
//                fuse so bombs expire within a few dozen cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bomb_timer;

    logic         clk;
    logic         rst_n;
    logic         p1_set_bomb;
    logic [7:0]   p1_coordinate;
    logic         p2_set_bomb;
    logic [7:0]   p2_coordinate;
    logic [255:0] flame_map;
    logic         explode_ready;
    logic         explode_valid;
    logic [7:0]   explode_coord;
    logic         explode_owner;
    logic [2:0]   bomb_num_1;
    logic [2:0]   bomb_num_2;
    logic [255:0] bomb_wall_o;

    int n_assert = 0;
    int n_fail   = 0;

    bomb_timer #(
        .SLOTS_PER_PLAYER (5),
        .FUSE_TICKS       (3),
        .TICK_DIV         (4),
        .TICK_W           (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .p1_set_bomb   (p1_set_bomb),
        .p1_coordinate (p1_coordinate),
        .p2_set_bomb   (p2_set_bomb),
        .p2_coordinate (p2_coordinate),
        .flame_map     (flame_map),
        .explode_ready (explode_ready),
        .explode_valid (explode_valid),
        .explode_coord (explode_coord),
        .explode_owner (explode_owner),
        .bomb_num_1    (bomb_num_1),
        .bomb_num_2    (bomb_num_2),
        .bomb_wall_o   (bomb_wall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic place(input logic p1, input logic [7:0] c1, input logic p2, input logic [7:0] c2);
        p1_set_bomb   = p1;
        p1_coordinate = c1;
        p2_set_bomb   = p2;
        p2_coordinate = c2;
        cyc();
        p1_set_bomb = 1'b0;
        p2_set_bomb = 1'b0;
    endtask

    // Wait for explode_valid with a cycle budget; k = edges waited.
    task automatic wait_valid(input int bound, output int k);
        k = 0;
        while (!explode_valid && k < bound) begin
            cyc();
            k++;
        end
        chk("wait_valid_timeout", 256'(explode_valid), 256'(1));
    endtask

    // Accept everything until both banks are empty.
    task automatic drain(input string tag);
        int k;
        explode_ready = 1'b1;
        k = 0;
        while ((bomb_num_1 != 3'd0 || bomb_num_2 != 3'd0 || explode_valid) && k < 100) begin
            cyc();
            k++;
        end
        chk(tag, {bomb_wall_o}, 256'(0));
        chk({tag, "_counts"}, 256'({bomb_num_1, bomb_num_2, explode_valid}), 256'(0));
    endtask

    initial begin
        int k;
        int seen;
        rst_n         = 1'b0;
        p1_set_bomb   = 1'b0;
        p1_coordinate = 8'h00;
        p2_set_bomb   = 1'b0;
        p2_coordinate = 8'h00;
        flame_map     = '0;
        explode_ready = 1'b1;
        cyc();
        cyc();

        // Reset state
        chk("rst_valid", 256'(explode_valid), 256'(0));
        chk("rst_coord_owner", 256'({explode_coord, explode_owner}), 256'(0));
        chk("rst_counts", 256'({bomb_num_1, bomb_num_2}), 256'(0));
        chk("rst_wall", bomb_wall_o, 256'(0));
        rst_n = 1'b1;
        cyc();

        // Single bomb life cycle
        place(1'b1, 8'h11, 1'b0, 8'h00);
        chk("t1_num1", 256'(bomb_num_1), 256'(1));
        chk("t1_wall", bomb_wall_o, 256'(1) << 17);
        wait_valid(40, k);
        chk("t1_latency_in_range", 256'(k >= 10 && k <= 13), 256'(1));
        chk("t1_coord", 256'(explode_coord), 256'(8'h11));
        chk("t1_owner", 256'(explode_owner), 256'(0));
        cyc();
        chk("t1_freed_num1", 256'(bomb_num_1), 256'(0));
        chk("t1_freed_wall", bomb_wall_o, 256'(0));
        chk("t1_freed_valid", 256'(explode_valid), 256'(0));

        // Bank capacity: five accepted, sixth dropped, seventh after one frees
        explode_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            place(1'b1, 8'(8'h40 + i), 1'b0, 8'h00);
        end
        chk("t2_num1_full", 256'(bomb_num_1), 256'(5));
        place(1'b1, 8'h45, 1'b0, 8'h00);
        chk("t2_sixth_num1", 256'(bomb_num_1), 256'(5));
        chk("t2_sixth_wall", bomb_wall_o, 256'(5'h1f) << 8'h40);
        wait_valid(40, k);
        chk("t2_first_coord", 256'(explode_coord), 256'(8'h40));
        explode_ready = 1'b1;
        cyc();
        explode_ready = 1'b0;
        chk("t2_after_pop_num1", 256'(bomb_num_1), 256'(4));
        chk("t2_after_pop_wall40", 256'(bomb_wall_o[8'h40]), 256'(0));
        place(1'b1, 8'h46, 1'b0, 8'h00);
        chk("t2_seventh_num1", 256'(bomb_num_1), 256'(5));
        chk("t2_seventh_wall46", 256'(bomb_wall_o[8'h46]), 256'(1));
        drain("t2_drain");

        // Same-cell conflict: player 1 wins, later p2 on the occupied cell dropped
        explode_ready = 1'b0;
        place(1'b1, 8'h22, 1'b1, 8'h22);
        chk("t3_nums", 256'({bomb_num_1, bomb_num_2}), 256'({3'd1, 3'd0}));
        chk("t3_wall", bomb_wall_o, 256'(1) << 8'h22);
        place(1'b0, 8'h00, 1'b1, 8'h22);
        chk("t3_p2_dropped", 256'(bomb_num_2), 256'(0));
        drain("t3_drain");

        // Two bombs expire together; stalled event held, then lowest index first
        explode_ready = 1'b0;
        place(1'b1, 8'h50, 1'b1, 8'h51);
        chk("t4_nums", 256'({bomb_num_1, bomb_num_2}), 256'({3'd1, 3'd1}));
        wait_valid(40, k);
        chk("t4_first", 256'({explode_coord, explode_owner}), 256'({8'h50, 1'b0}));
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t4_hold", 256'({explode_valid, explode_coord, explode_owner}),
                256'({1'b1, 8'h50, 1'b0}));
        end
        explode_ready = 1'b1;
        cyc();
        chk("t4_second", 256'({explode_valid, explode_coord, explode_owner}),
            256'({1'b1, 8'h51, 1'b1}));
        chk("t4_mid_nums", 256'({bomb_num_1, bomb_num_2}), 256'({3'd0, 3'd1}));
        cyc();
        chk("t4_done", 256'({explode_valid, bomb_num_1, bomb_num_2}), 256'(0));
        chk("t4_wall", bomb_wall_o, 256'(0));

        // Flame chain reaction forces an armed bomb pending next cycle
        explode_ready = 1'b0;
        place(1'b1, 8'h30, 1'b0, 8'h00);
        chk("t5_armed_not_valid", 256'(explode_valid), 256'(0));
        flame_map[48] = 1'b1;
        cyc();
        flame_map = '0;
        chk("t5_flame_valid", 256'({explode_valid, explode_coord, explode_owner}),
            256'({1'b1, 8'h30, 1'b0}));

        // Reset while an event is presented
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 256'({explode_valid, explode_coord, explode_owner}), 256'(0));
        chk("t6_rst_counts", 256'({bomb_num_1, bomb_num_2}), 256'(0));
        chk("t6_rst_wall", bomb_wall_o, 256'(0));
        cyc();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (explode_valid) seen++;
        end
        chk("t6_no_event_after_release", 256'(seen), 256'(0));
        chk("t6_counts_after_release", 256'({bomb_num_1, bomb_num_2}), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
